// File: rtl/cpu_reg_latch_dec_pkg.sv
// Shared definitions for the CPU bus register decoder: FSM encodings, index
// width helper and the flat-vector slice macro used by the top level.
`ifndef CPU_REG_LATCH_DEC_PKG_SV
`define CPU_REG_LATCH_DEC_PKG_SV

// Element idx of width w inside a flat packed vector.
`define CRLD_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package cpu_reg_latch_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_COMMIT = 2'd2
    } crld_state_t;

    localparam int MAX_REGS = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/cpu_reg_latch_dec_phi2_sync.sv
// Synchroniser for the CPU phase-2 clock into the hsclk domain.
// o_s0 is the first flop, o_ps the last, o_pd is o_ps delayed one hsclk.
module cpu_reg_latch_dec_phi2_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic hsclk,
    input  logic reset,
    input  logic cpu_phi2,
    output logic o_s0,
    output logic o_ps,
    output logic o_pd
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pd;

    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_pd   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cpu_phi2};
            r_pd   <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s0 = r_sync[0];
    assign o_ps = r_sync[SYNC_STAGES-1];
    assign o_pd = r_pd;

endmodule

// File: rtl/cpu_reg_latch_dec.sv
// Decodes write-only board registers from the 65816 bus, committing each write
// at the end of the phi2 cycle, with optional write-once lock and readback.
module cpu_reg_latch_dec
    import cpu_reg_latch_dec_pkg::*;
#(
    parameter int                         ADDR_W      = 16,
    parameter int                         DATA_W      = 8,
    parameter int                         NUM_REGS    = 4,
    parameter logic [NUM_REGS*ADDR_W-1:0] REG_ADDRS   = {16'hFE41, 16'hFE40, 16'hFE34, 16'hFE30},
    parameter logic [NUM_REGS*DATA_W-1:0] REG_RESET   = {8'h80, 8'h0F, 8'h00, 8'h00},
    parameter logic [NUM_REGS-1:0]        LOCK_MASK   = '0,
    parameter int                         SYNC_STAGES = 2
) (
    input  logic                         hsclk,
    input  logic                         reset,
    input  logic                         cpu_phi2,
    input  logic                         cpu_vda,
    input  logic                         cpu_rnw,
    input  logic [ADDR_W-1:0]            cpu_a,
    input  logic [DATA_W-1:0]            cpu_d,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic [NUM_REGS-1:0]          locked,
    output logic                         rd_oe,
    output logic [DATA_W-1:0]            rd_data,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = idx_width(NUM_REGS);

    // Synchronised phi2 views
    logic w_s0;
    logic w_ps;
    logic w_pd;

    // Bus hold registers, loaded while phi2 (first sync stage) is high
    logic [ADDR_W-1:0] r_a_h;
    logic [DATA_W-1:0] r_d_h;
    logic              r_vda_h;
    logic              r_rnw_h;

    crld_state_t                 r_state;
    logic [NUM_REGS*DATA_W-1:0]  r_reg_q;
    logic [NUM_REGS-1:0]         r_wr_stb;
    logic [NUM_REGS-1:0]         r_locked;
    logic                        r_rd_oe;
    logic [DATA_W-1:0]           r_rd_data;
    logic [IDX_W-1:0]            r_cmt_idx;
    logic [DATA_W-1:0]           r_cmt_data;

    logic [NUM_REGS-1:0]         w_hit;
    logic                        w_any_hit;
    logic [IDX_W-1:0]            w_win_idx;
    logic [DATA_W-1:0]           w_win_q;

    cpu_reg_latch_dec_phi2_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_phi2_sync (
        .hsclk    (hsclk),
        .reset    (reset),
        .cpu_phi2 (cpu_phi2),
        .o_s0     (w_s0),
        .o_ps     (w_ps),
        .o_pd     (w_pd)
    );

    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            r_a_h   <= '0;
            r_d_h   <= '0;
            r_vda_h <= 1'b0;
            r_rnw_h <= 1'b0;
        end else if (w_s0) begin
            r_a_h   <= cpu_a;
            r_d_h   <= cpu_d;
            r_vda_h <= cpu_vda;
            r_rnw_h <= cpu_rnw;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i] = r_vda_h && (r_a_h == `CRLD_SLICE(REG_ADDRS, i, ADDR_W));
        end
    end

    assign w_any_hit = |w_hit;

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        w_win_idx = '0;
        w_win_q   = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_idx = IDX_W'(i);
                w_win_q   = `CRLD_SLICE(r_reg_q, i, DATA_W);
            end
        end
    end

    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_reg_q    <= REG_RESET;
            r_wr_stb   <= '0;
            r_locked   <= '0;
            r_rd_oe    <= 1'b0;
            r_rd_data  <= '0;
            r_cmt_idx  <= '0;
            r_cmt_data <= '0;
        end else begin
            r_wr_stb  <= '0;
            r_rd_oe   <= 1'b0;
            r_rd_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ps) begin
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_any_hit && r_rnw_h) begin
                        r_rd_oe   <= 1'b1;
                        r_rd_data <= w_win_q;
                    end
                    if (!w_ps && w_pd) begin
                        // Target and data are frozen here so a quick phi2 return
                        // reloading the hold registers cannot alter the commit.
                        if (r_vda_h && !r_rnw_h && w_any_hit) begin
                            r_state    <= ST_COMMIT;
                            r_cmt_idx  <= w_win_idx;
                            r_cmt_data <= r_d_h;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if ((r_cmt_idx == IDX_W'(i)) && !(LOCK_MASK[i] && r_locked[i])) begin
                            `CRLD_SLICE(r_reg_q, i, DATA_W) <= r_cmt_data;
                            r_wr_stb[i] <= 1'b1;
                            r_locked[i] <= LOCK_MASK[i];
                        end
                    end
                    r_state <= w_ps ? ST_HIGH : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_q     = r_reg_q;
    assign wr_stb    = r_wr_stb;
    assign locked    = r_locked;
    assign rd_oe     = r_rd_oe;
    assign rd_data   = r_rd_data;
    assign dbg_state = r_state;

endmodule
